// File: rtl/multicycle_controller.sv
// Control unit for the multicycle MIPS datapath: Moore main decoder FSM plus
// a combinational ALU decoder. Outputs are decoded from the current state.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regdst,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       lord,
  output logic       memwrite,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;
  aluop_t aluop;
  logic   pcwrite;
  logic   branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Unused encodings fall through to the all-zero defaults.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    pcsrc    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    regdst   = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    irwrite  = 1'b0;
    lord     = 1'b0;
    memwrite = 1'b0;
    aluop    = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   lord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        lord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      ALUOP_SUB: alucontrol = 3'b110;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default:   alucontrol = 3'b010;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised instruction stream against a per-instruction reference model;
// expected outputs are queued per cycle and checked by an independent monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       pcen, alusrca, regdst, regwrite, memtoreg, irwrite, lord, memwrite;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       regwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       lord;
    logic       memwrite;
    logic [2:0] aluc;
  } outv_t;

  typedef int seq_t[$];

  outv_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg),
    .irwrite(irwrite), .lord(lord), .memwrite(memwrite),
    .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // States visited by one instruction, starting at FETCH.
  function automatic seq_t states_for(input logic [5:0] o);
    case (o)
      6'b100011: return '{0, 1, 2, 3, 4};
      6'b101011: return '{0, 1, 2, 5};
      6'b000000: return '{0, 1, 6, 7};
      6'b000100: return '{0, 1, 8};
      6'b001000: return '{0, 1, 9, 10};
      6'b000010: return '{0, 1, 11};
      default:   return '{0, 1};
    endcase
  endfunction

  function automatic outv_t model(input int s, input logic [5:0] f, input logic z);
    outv_t e;
    int    kind;
    e    = '0;
    kind = 0;
    e.st = 4'(s);
    case (s)
      0:  begin e.irwrite = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1; end
      1:  e.alusrcb = 2'b11;
      2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      3:  e.lord = 1'b1;
      4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      5:  begin e.lord = 1'b1; e.memwrite = 1'b1; end
      6:  begin e.alusrca = 1'b1; kind = 2; end
      7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      8:  begin e.alusrca = 1'b1; kind = 1; e.pcsrc = 2'b01; e.pcen = z; end
      9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      10: e.regwrite = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: ;
    endcase
    e.aluc = (kind == 1) ? 3'b110 : (kind == 2) ? alu_of_funct(f) : 3'b010;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_cycle(input int s, input logic [5:0] o, input logic [5:0] f,
                            input logic z);
    @(posedge clk);
    #1;
    op    = o;
    funct = f;
    zero  = z;
    q.push_back(model(s, f, z));
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input bit skip_fetch);
    seq_t s;
    s = states_for(o);
    for (int i = skip_fetch ? 1 : 0; i < s.size(); i++) push_cycle(s[i], o, f, z);
  endtask

  // Holds reset for one full cycle expecting FETCH, then releases it mid-cycle.
  task automatic reset_cycle();
    push_cycle(0, op, funct, zero);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    outv_t exp;
    outv_t act;
    cyc++;
    if (q.size() > 0) begin
      exp = q.pop_front();
      act = '{state, pcen, pcsrc, alusrca, alusrcb, regdst, regwrite, memtoreg,
              irwrite, lord, memwrite, alucontrol};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL cycle%0d outputs: got st=%0d vec=%b expected st=%0d vec=%b",
                 cyc, act.st, act, exp.st, exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] kops [6];
    logic [5:0] kfun [6];
    logic [5:0] o, f;
    kops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    kfun = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

    #1;
    chk("reset_state_async", int'(state), 0);
    chk("reset_irwrite", int'(irwrite), 1);
    chk("reset_pcen", int'(pcen), 1);
    reset_cycle();

    run_instr(6'b100011, 6'h00, 1'b0, 1'b1);
    run_instr(6'b101011, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) run_instr(6'b000000, kfun[i], 1'b0, 1'b0);
    run_instr(6'b000100, 6'h00, 1'b1, 1'b0);
    run_instr(6'b000100, 6'h00, 1'b0, 1'b0);
    run_instr(6'b000010, 6'h00, 1'b0, 1'b0);
    run_instr(6'b111111, 6'h00, 1'b0, 1'b0);
    run_instr(6'b001000, 6'h00, 1'b0, 1'b0);

    // Abort an R-type in EXECUTE with an asynchronous reset.
    push_cycle(0, 6'b000000, 6'h2A, 1'b0);
    push_cycle(1, 6'b000000, 6'h2A, 1'b0);
    push_cycle(6, 6'b000000, 6'h2A, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midexec_reset_state", int'(state), 0);
    chk("midexec_reset_irwrite", int'(irwrite), 1);
    chk("midexec_reset_alusrcb", int'(alusrcb), 1);
    chk("midexec_reset_pcen", int'(pcen), 1);
    chk("midexec_reset_regwrite", int'(regwrite), 0);
    reset_cycle();
    run_instr(6'b101011, 6'h00, 1'b0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 7);
      o = (r < 6) ? kops[r] : (r == 6) ? 6'($urandom) : 6'b000000;
      r = $urandom_range(0, 6);
      f = (r < 6) ? kfun[r] : 6'($urandom);
      run_instr(o, f, 1'($urandom), 1'b0);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
